// File: rtl/i3c_master_fsm.sv
// I3C SDR master controller for one private single-byte transfer (write or read).
// Generates SCL and drives/samples SDA through START, address+RnW, ACK, data byte + ninth bit and STOP.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 3
`endif
`ifndef I3C_ST_IDLE
`define I3C_ST_IDLE     3'd0
`define I3C_ST_START    3'd1
`define I3C_ST_ADDR     3'd2
`define I3C_ST_ADDR_ACK 3'd3
`define I3C_ST_DATA     3'd4
`define I3C_ST_STOP     3'd5
`endif

module i3c_master_fsm #(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    rnw_i,
    input  logic [`DATA_WIDTH-1:0]  wdata_i,
    input  logic                    sda_i,
    output logic                    scl_o,
    output logic                    sda_o,
    output logic                    sda_oe_o,
    output logic [`STATE_WIDTH-1:0] state_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    nack_o,
    output logic [`DATA_WIDTH-1:0]  rdata_o
);

    localparam int DW = `DATA_WIDTH;
    localparam int CW = (CLK_DIV >= 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [3:0] ADDR_LAST      = 4'(ADDR_WIDTH);
    localparam logic [3:0] DATA_NINTH     = 4'(DW);
    localparam logic [3:0] DATA_LAST_BIT  = 4'(DW - 1);

    typedef enum logic [`STATE_WIDTH-1:0] {
        ST_IDLE     = `I3C_ST_IDLE,
        ST_START    = `I3C_ST_START,
        ST_ADDR     = `I3C_ST_ADDR,
        ST_ADDR_ACK = `I3C_ST_ADDR_ACK,
        ST_DATA     = `I3C_ST_DATA,
        ST_STOP     = `I3C_ST_STOP
    } state_t;

    state_t              state;
    logic [CW-1:0]       half_cnt;
    logic [1:0]          phase;
    logic [3:0]          bit_cnt;
    logic [ADDR_WIDTH:0] addr_shift;
    logic [DW-1:0]       tx_shift;
    logic [DW-1:0]       rx_shift;
    logic                rnw_q;
    logic                sampled;

    logic half_last;
    logic in_slot;
    logic scl_rise;
    logic sample_pt;
    logic slot_end;

    // Bit slots are a low half-period followed by a high half-period; phase 0 = low, 1 = high.
    assign half_last = (half_cnt == HALF_LAST);
    assign in_slot   = (state == ST_ADDR) || (state == ST_ADDR_ACK) || (state == ST_DATA);
    assign scl_rise  = in_slot && (phase == 2'd0) && half_last;
    assign sample_pt = in_slot && (phase == 2'd1) && (half_cnt == '0);
    assign slot_end  = in_slot && (phase == 2'd1) && half_last;
    assign state_o   = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            half_cnt   <= '0;
            phase      <= 2'd0;
            bit_cnt    <= 4'd0;
            addr_shift <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rnw_q      <= 1'b0;
            sampled    <= 1'b0;
            scl_o      <= 1'b1;
            sda_o      <= 1'b1;
            sda_oe_o   <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            nack_o     <= 1'b0;
            rdata_o    <= '0;
        end else begin
            done_o <= 1'b0;
            if (state != ST_IDLE) begin
                half_cnt <= half_last ? '0 : half_cnt + CW'(1);
            end
            if (scl_rise) begin
                phase <= 2'd1;
                scl_o <= 1'b1;
            end
            if (slot_end) begin
                phase <= 2'd0;
                scl_o <= 1'b0;
            end
            if (sample_pt) begin
                sampled <= sda_i;
                if (state == ST_DATA && rnw_q && bit_cnt != DATA_NINTH) begin
                    rx_shift <= {rx_shift[DW-2:0], sda_i};
                end
            end

            case (state)
                ST_IDLE: begin
                    half_cnt <= '0;
                    phase    <= 2'd0;
                    bit_cnt  <= 4'd0;
                    if (start_i) begin
                        addr_shift <= {addr_i, rnw_i};
                        rnw_q      <= rnw_i;
                        tx_shift   <= wdata_i;
                        nack_o     <= 1'b0;
                        busy_o     <= 1'b1;
                        scl_o      <= 1'b1;
                        sda_o      <= 1'b0;
                        sda_oe_o   <= 1'b1;
                        state      <= ST_START;
                    end
                end

                ST_START: begin
                    if (half_last) begin
                        if (phase == 2'd0) begin
                            phase <= 2'd1;
                            scl_o <= 1'b0;
                        end else begin
                            phase   <= 2'd0;
                            bit_cnt <= 4'd0;
                            sda_o   <= addr_shift[ADDR_WIDTH];
                            state   <= ST_ADDR;
                        end
                    end
                end

                ST_ADDR: begin
                    if (slot_end) begin
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt  <= 4'd0;
                            sda_oe_o <= 1'b0;
                            sda_o    <= 1'b1;
                            state    <= ST_ADDR_ACK;
                        end else begin
                            bit_cnt    <= bit_cnt + 4'd1;
                            addr_shift <= {addr_shift[ADDR_WIDTH-1:0], 1'b0};
                            sda_o      <= addr_shift[ADDR_WIDTH-1];
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (slot_end) begin
                        if (sampled) begin
                            nack_o   <= 1'b1;
                            sda_oe_o <= 1'b1;
                            sda_o    <= 1'b0;
                            state    <= ST_STOP;
                        end else begin
                            bit_cnt  <= 4'd0;
                            sda_oe_o <= ~rnw_q;
                            sda_o    <= rnw_q ? 1'b1 : tx_shift[DW-1];
                            state    <= ST_DATA;
                        end
                    end
                end

                // Slots 0..DW-1 carry the byte; slot DW is the ninth bit (target ACK or master end-of-read).
                ST_DATA: begin
                    if (slot_end) begin
                        if (bit_cnt == DATA_NINTH) begin
                            if (rnw_q) begin
                                rdata_o <= rx_shift;
                            end else if (sampled) begin
                                nack_o <= 1'b1;
                            end
                            sda_oe_o <= 1'b1;
                            sda_o    <= 1'b0;
                            state    <= ST_STOP;
                        end else if (bit_cnt == DATA_LAST_BIT) begin
                            bit_cnt  <= DATA_NINTH;
                            sda_oe_o <= rnw_q;
                            sda_o    <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            tx_shift <= {tx_shift[DW-2:0], 1'b0};
                            if (!rnw_q) begin
                                sda_o <= tx_shift[DW-2];
                            end
                        end
                    end
                end

                // STOP: SCL low/SDA low, then SCL high/SDA low, then SDA high for the bus-free time.
                ST_STOP: begin
                    if (half_last) begin
                        case (phase)
                            2'd0: begin
                                phase <= 2'd1;
                                scl_o <= 1'b1;
                            end
                            2'd1: begin
                                phase <= 2'd2;
                                sda_o <= 1'b1;
                            end
                            default: begin
                                phase  <= 2'd0;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i3c_master_fsm.sv
// Self-checking bench for i3c_master_fsm: a bus-level target model answers ACK/NACK and read data,
// while each transfer is compared against the protocol-level expectations for bits, timing and status.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 3
`endif
`ifndef I3C_ST_IDLE
`define I3C_ST_IDLE     3'd0
`define I3C_ST_START    3'd1
`define I3C_ST_ADDR     3'd2
`define I3C_ST_ADDR_ACK 3'd3
`define I3C_ST_DATA     3'd4
`define I3C_ST_STOP     3'd5
`endif

module tb_i3c_master_fsm;

    localparam int D  = 4;
    localparam int AW = 7;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b0;
    logic                    start_i = 1'b0;
    logic [AW-1:0]           addr_i = '0;
    logic                    rnw_i = 1'b0;
    logic [`DATA_WIDTH-1:0]  wdata_i = '0;
    logic                    sda_i = 1'b1;
    logic                    scl_o;
    logic                    sda_o;
    logic                    sda_oe_o;
    logic [`STATE_WIDTH-1:0] state_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    nack_o;
    logic [`DATA_WIDTH-1:0]  rdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    model_rdata = 8'h00;
    logic [AW-1:0] pend_addr;
    logic          pend_rnw;
    logic [7:0]    pend_wdata;
    bit            pend_valid = 1'b0;

    i3c_master_fsm #(.CLK_DIV(D), .ADDR_WIDTH(AW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .addr_i   (addr_i),
        .rnw_i    (rnw_i),
        .wdata_i  (wdata_i),
        .sda_i    (sda_i),
        .scl_o    (scl_o),
        .sda_o    (sda_o),
        .sda_oe_o (sda_oe_o),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .nack_o   (nack_o),
        .rdata_o  (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] global timeout");
    end

    // Presents a request at a negedge and returns just after the accepting posedge, start_i still high.
    task automatic apply_stimulus(input logic [AW-1:0] a, input logic r, input logic [7:0] w);
        @(negedge clk_i);
        addr_i  = a;
        rnw_i   = r;
        wdata_i = w;
        start_i = 1'b1;
        @(posedge clk_i);
    endtask

    // Watches one transfer from the accepting edge to done_o, acting as the addressed target on sda_i.
    task automatic observe(input bit keep_start, input bit na, input bit nd, input bit r,
                           input logic [7:0] rd, output int cycles, output logic [31:0] rs,
                           output logic [31:0] ro, output int nrise, output int nstop,
                           output int nstart, output logic [23:0] seq, output int busy_bad,
                           output bit timeout);
        logic       prev_scl;
        logic       prev_sda;
        logic [2:0] prev_state;
        int         slot;
        bit         finished;
        rs = '0; ro = '0; nrise = 0; nstop = 0; nstart = 0; seq = '0;
        busy_bad = 0; timeout = 1'b0; cycles = -1; finished = 1'b0;
        prev_scl = 1'b1; prev_sda = 1'b1; prev_state = `I3C_ST_IDLE;
        while (!finished) begin
            @(negedge clk_i);
            cycles++;
            if (cycles == 0) begin
                if (!keep_start) start_i = 1'b0;
                if (pend_valid) begin
                    addr_i = pend_addr; rnw_i = pend_rnw; wdata_i = pend_wdata;
                    pend_valid = 1'b0;
                end
            end
            if (state_o != prev_state) begin
                seq = {seq[20:0], state_o};
                if (state_o == `I3C_ST_START) nstart++;
            end
            if (scl_o && !prev_scl) begin
                if (nrise < 32) begin
                    rs[nrise] = sda_o;
                    ro[nrise] = sda_oe_o;
                end
                nrise++;
            end
            if (!scl_o && prev_scl) begin
                slot = nrise;
                if (slot == 8) sda_i = na;
                else if (r && slot >= 9 && slot <= 16) sda_i = rd[16-slot];
                else if (!r && slot == 17) sda_i = nd;
                else sda_i = 1'b1;
            end
            if (scl_o && prev_scl && !prev_sda && sda_o) nstop++;
            if (done_o) begin
                if (busy_o) busy_bad++;
                finished = 1'b1;
            end else begin
                if (!busy_o) busy_bad++;
                if (cycles > 41 * D + 40) begin
                    timeout = 1'b1;
                    finished = 1'b1;
                end
            end
            prev_scl = scl_o; prev_sda = sda_o; prev_state = state_o;
        end
        sda_i = 1'b1;
    endtask

    // Runs one transfer and compares it against expectations derived from the protocol rules.
    task automatic verify_transfer(input string tag, input logic [AW-1:0] a, input logic r,
                                   input logic [7:0] w, input bit na, input bit nd,
                                   input logic [7:0] rd, input bit accepted, input bit keep_start);
        logic [7:0]  abyte;
        logic [31:0] es, eo, rs, ro, rmask;
        logic [23:0] seq, eseq;
        int cycles, nrise, nstop, nstart, busy_bad, n_exp, exp_lat;
        bit timeout, exp_nack;
        abyte = {a, r};
        es = '0; eo = '0;
        for (int i = 0; i < 8; i++) begin
            es[i] = abyte[7-i];
            eo[i] = 1'b1;
        end
        eseq = '0;
        eseq = {eseq[20:0], `I3C_ST_START};
        eseq = {eseq[20:0], `I3C_ST_ADDR};
        eseq = {eseq[20:0], `I3C_ST_ADDR_ACK};
        if (na) begin
            es[9] = 1'b0; eo[9] = 1'b1;
            n_exp = 10;
            exp_lat = 23 * D;
        end else begin
            for (int i = 0; i < 8; i++) begin
                es[9+i] = r ? 1'b0 : w[7-i];
                eo[9+i] = ~r;
            end
            es[17] = 1'b1; eo[17] = r;
            es[18] = 1'b0; eo[18] = 1'b1;
            n_exp = 19;
            exp_lat = 41 * D;
            eseq = {eseq[20:0], `I3C_ST_DATA};
        end
        eseq = {eseq[20:0], `I3C_ST_STOP};
        eseq = {eseq[20:0], `I3C_ST_IDLE};
        rmask = (32'h1 << n_exp) - 32'h1;
        exp_nack = na | (~r & nd);
        if (!na && r) model_rdata = rd;

        if (!accepted) apply_stimulus(a, r, w);
        else @(posedge clk_i);
        observe(keep_start, na, nd, r, rd, cycles, rs, ro, nrise, nstop, nstart, seq, busy_bad, timeout);

        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s done_wait: timed out after %0d cycles, required done within %0d", tag, cycles, exp_lat);
        end
        n_checks++;
        if (cycles !== exp_lat) begin
            n_fail++;
            $display("[TB] FAIL %s latency: got %0d cycles, required %0d", tag, cycles, exp_lat);
        end
        n_checks++;
        if (nrise !== n_exp) begin
            n_fail++;
            $display("[TB] FAIL %s scl_pulses: got %0d, required %0d", tag, nrise, n_exp);
        end
        n_checks++;
        if (((rs ^ es) & eo & rmask) !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL %s sda_bits: got %h, required %h (mask %h)", tag, rs & eo & rmask, es & eo & rmask, eo & rmask);
        end
        n_checks++;
        if ((ro & rmask) !== (eo & rmask)) begin
            n_fail++;
            $display("[TB] FAIL %s sda_oe_bits: got %h, required %h", tag, ro & rmask, eo & rmask);
        end
        n_checks++;
        if (nack_o !== exp_nack) begin
            n_fail++;
            $display("[TB] FAIL %s nack: got %b, required %b", tag, nack_o, exp_nack);
        end
        n_checks++;
        if (rdata_o !== model_rdata) begin
            n_fail++;
            $display("[TB] FAIL %s rdata: got %h, required %h", tag, rdata_o, model_rdata);
        end
        n_checks++;
        if (seq !== eseq) begin
            n_fail++;
            $display("[TB] FAIL %s state_sequence: got %h, required %h", tag, seq, eseq);
        end
        n_checks++;
        if (nstop !== 1 || nstart !== 1) begin
            n_fail++;
            $display("[TB] FAIL %s start_stop_count: got start=%0d stop=%0d, required 1 and 1", tag, nstart, nstop);
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL %s busy: got %0d bad cycles, required 0", tag, busy_bad);
        end
        if (!keep_start) begin
            @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b0 || state_o !== `I3C_ST_IDLE) begin
                n_fail++;
                $display("[TB] FAIL %s done_pulse: got done=%b state=%0d, required done=0 state=%0d", tag, done_o, state_o, `I3C_ST_IDLE);
            end
        end
    endtask

    task automatic test_reset();
        int  waited;
        int  bad;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        n_checks++;
        if ({state_o, scl_o, sda_o, sda_oe_o, busy_o, done_o, nack_o} !== {`I3C_ST_IDLE, 6'b111000}) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got state=%0d scl=%b sda=%b oe=%b busy=%b done=%b nack=%b, required 0 1 1 1 0 0 0",
                     state_o, scl_o, sda_o, sda_oe_o, busy_o, done_o, nack_o);
        end
        n_checks++;
        if (rdata_o !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_rdata: got %h, required 00", rdata_o);
        end

        apply_stimulus(7'h55, 1'b0, 8'h12);
        @(negedge clk_i);
        start_i = 1'b0;
        waited = 0;
        while (state_o !== `I3C_ST_ADDR && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        n_checks++;
        if (state_o !== `I3C_ST_ADDR) begin
            n_fail++;
            $display("[TB] FAIL reset_reach_addr: got state %0d, required %0d", state_o, `I3C_ST_ADDR);
        end
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        n_checks++;
        if ({state_o, scl_o, sda_o, sda_oe_o, busy_o, nack_o} !== {`I3C_ST_IDLE, 5'b11100}) begin
            n_fail++;
            $display("[TB] FAIL reset_midaddr: got state=%0d scl=%b sda=%b oe=%b busy=%b nack=%b, required 0 1 1 1 0 0",
                     state_o, scl_o, sda_o, sda_oe_o, busy_o, nack_o);
        end
        bad = 0;
        repeat (6 * D) begin
            @(negedge clk_i);
            if (scl_o !== 1'b1 || sda_o !== 1'b1 || done_o !== 1'b0 || state_o !== `I3C_ST_IDLE) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_stop: got %0d non-idle bus cycles, required 0", bad);
        end
    endtask

    task automatic test_write();
        verify_transfer("write", 7'h52, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_read();
        verify_transfer("read", 7'h1F, 1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    endtask

    task automatic test_addr_nack();
        verify_transfer("addr_nack", 7'h2A, 1'b1, 8'h77, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    endtask

    task automatic test_wdata_nack();
        int waited;
        verify_transfer("wdata_nack", 7'h0B, 1'b0, 8'h5E, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        apply_stimulus(7'h33, 1'b0, 8'h81);
        @(negedge clk_i);
        start_i = 1'b0;
        n_checks++;
        if (nack_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL nack_clear: got nack=%b busy=%b, required nack=0 busy=1", nack_o, busy_o);
        end
        waited = 0;
        while (done_o !== 1'b1 && waited < 41 * D + 40) begin
            @(negedge clk_i);
            waited++;
        end
        n_checks++;
        if (done_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL nack_clear_done: done not seen after %0d cycles, required done", waited);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        pend_addr  = 7'h6D;
        pend_rnw   = 1'b1;
        pend_wdata = 8'hFF;
        pend_valid = 1'b1;
        verify_transfer("b2b_first", 7'h21, 1'b0, 8'h96, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        verify_transfer("b2b_second", 7'h6D, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h4B, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic          r;
        logic [7:0]    w;
        logic [7:0]    rd;
        bit            na;
        bit            nd;
        for (int k = 0; k < 10; k++) begin
            a  = AW'($urandom);
            r  = 1'($urandom);
            w  = 8'($urandom);
            rd = 8'($urandom);
            na = ($urandom_range(0, 3) == 0);
            nd = ($urandom_range(0, 2) == 0);
            verify_transfer($sformatf("random_%0d", k), a, r, w, na, nd, rd, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_wdata_nack();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
